// File: rtl/prirv32_mem_arbiter_pkg.sv
// Shared definitions for the prirv32 memory arbiter: FSM and owner encodings,
// default parameter values.
package prirv32_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } owner_e;

  localparam int unsigned STARVE_LIMIT_DEF   = 4;
  localparam int unsigned TIMEOUT_CYCLES_DEF = 255;

endpackage

// File: rtl/prirv32_arb_prio.sv
// Fixed-priority grant (load/store first) with a fetch starvation guard.
// Owns the starvation counter; grants are only issued while i_idle is high.
module prirv32_arb_prio
  import prirv32_mem_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic clk_i,
  input  logic rst_n,
  input  logic i_idle,
  input  logic i_if_req,
  input  logic i_ls_req,
  output logic o_if_gnt,
  output logic o_ls_gnt
);

  localparam int unsigned CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

  logic [CNT_W-1:0] r_starve_cnt;
  logic             w_starved;

  assign w_starved = (r_starve_cnt == CNT_W'(STARVE_LIMIT));

  always_comb begin
    o_if_gnt = 1'b0;
    o_ls_gnt = 1'b0;
    if (i_idle) begin
      if (i_if_req && (!i_ls_req || w_starved)) begin
        o_if_gnt = 1'b1;
      end else if (i_ls_req) begin
        o_ls_gnt = 1'b1;
      end
    end
  end

  // A starved counter always hands the next grant to IF, so it never exceeds the limit.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      r_starve_cnt <= '0;
    end else if (o_if_gnt || (i_idle && !i_if_req)) begin
      r_starve_cnt <= '0;
    end else if (o_ls_gnt && i_if_req && !w_starved) begin
      r_starve_cnt <= r_starve_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/prirv32_mem_arbiter.sv
// Single-port memory bus arbiter between fetch (IF) and load/store (LS).
// Optional wait-state abort: define PRIRV32_MEM_TIMEOUT_EN.
module prirv32_mem_arbiter
  import prirv32_mem_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT   = STARVE_LIMIT_DEF,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic        clk_i,
  input  logic        rst_n,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic        if_gnt_o,
  output logic        if_rvalid_o,
  output logic [31:0] if_rdata_o,
  input  logic        ls_req_i,
  input  logic        ls_we_i,
  input  logic [3:0]  ls_be_i,
  input  logic [31:0] ls_addr_i,
  input  logic [31:0] ls_wdata_i,
  output logic        ls_gnt_o,
  output logic        ls_rvalid_o,
  output logic [31:0] ls_rdata_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_ready_i,
  input  logic [31:0] mem_rdata_i,
  output logic        if_err_o,
  output logic        ls_err_o
);

  if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
    $error("prirv32_mem_arbiter: TIMEOUT_CYCLES must be nonzero");
  end

  state_e      r_state;
  owner_e      r_owner;
  logic        r_mem_req;
  logic        r_mem_we;
  logic [3:0]  r_mem_be;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_wdata;
  logic        r_if_rvalid;
  logic        r_ls_rvalid;
  logic [31:0] r_if_rdata;
  logic [31:0] r_ls_rdata;
  logic        w_idle;
  logic        w_if_gnt;
  logic        w_ls_gnt;

`ifdef PRIRV32_MEM_TIMEOUT_EN
  localparam int unsigned WAIT_W =
    ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic              r_if_err;
  logic              r_ls_err;
`endif

  assign w_idle = (r_state == ST_IDLE);

  prirv32_arb_prio #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_arb_prio (
    .clk_i    (clk_i),
    .rst_n    (rst_n),
    .i_idle   (w_idle),
    .i_if_req (if_req_i),
    .i_ls_req (ls_req_i),
    .o_if_gnt (w_if_gnt),
    .o_ls_gnt (w_ls_gnt)
  );

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_owner     <= OWN_IF;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_be    <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_if_rvalid <= 1'b0;
      r_ls_rvalid <= 1'b0;
      r_if_rdata  <= '0;
      r_ls_rdata  <= '0;
`ifdef PRIRV32_MEM_TIMEOUT_EN
      r_wait_cnt  <= '0;
      r_if_err    <= 1'b0;
      r_ls_err    <= 1'b0;
`endif
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_ls_gnt) begin
            r_state     <= ST_BUSY;
            r_owner     <= OWN_LS;
            r_mem_req   <= 1'b1;
            r_mem_we    <= ls_we_i;
            r_mem_be    <= ls_be_i;
            r_mem_addr  <= ls_addr_i;
            r_mem_wdata <= ls_wdata_i;
          end else if (w_if_gnt) begin
            r_state     <= ST_BUSY;
            r_owner     <= OWN_IF;
            r_mem_req   <= 1'b1;
            r_mem_we    <= 1'b0;
            r_mem_be    <= '1;
            r_mem_addr  <= if_addr_i;
            r_mem_wdata <= '0;
          end
        end
        ST_BUSY: begin
          if (mem_ready_i) begin
            r_state   <= ST_RESP;
            r_mem_req <= 1'b0;
            if (r_owner == OWN_LS) begin
              r_ls_rvalid <= 1'b1;
              r_ls_rdata  <= r_mem_we ? '0 : mem_rdata_i;
            end else begin
              r_if_rvalid <= 1'b1;
              r_if_rdata  <= mem_rdata_i;
            end
`ifdef PRIRV32_MEM_TIMEOUT_EN
            r_wait_cnt <= '0;
          end else if (r_wait_cnt == WAIT_W'(TIMEOUT_CYCLES - 1)) begin
            // Abort completes like a normal response but with zero data and err.
            r_state    <= ST_RESP;
            r_mem_req  <= 1'b0;
            r_wait_cnt <= '0;
            if (r_owner == OWN_LS) begin
              r_ls_rvalid <= 1'b1;
              r_ls_rdata  <= '0;
              r_ls_err    <= 1'b1;
            end else begin
              r_if_rvalid <= 1'b1;
              r_if_rdata  <= '0;
              r_if_err    <= 1'b1;
            end
          end else begin
            r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
`endif
          end
        end
        ST_RESP: begin
          r_state     <= ST_IDLE;
          r_if_rvalid <= 1'b0;
          r_ls_rvalid <= 1'b0;
`ifdef PRIRV32_MEM_TIMEOUT_EN
          r_if_err    <= 1'b0;
          r_ls_err    <= 1'b0;
`endif
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign if_gnt_o    = w_if_gnt;
  assign ls_gnt_o    = w_ls_gnt;
  assign if_rvalid_o = r_if_rvalid;
  assign ls_rvalid_o = r_ls_rvalid;
  assign if_rdata_o  = r_if_rdata;
  assign ls_rdata_o  = r_ls_rdata;
  assign mem_req_o   = r_mem_req;
  assign mem_we_o    = r_mem_we;
  assign mem_be_o    = r_mem_be;
  assign mem_addr_o  = r_mem_addr;
  assign mem_wdata_o = r_mem_wdata;

`ifdef PRIRV32_MEM_TIMEOUT_EN
  assign if_err_o = r_if_err;
  assign ls_err_o = r_ls_err;
`else
  assign if_err_o = 1'b0;
  assign ls_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_prirv32_mem_arbiter.sv
// Directed bench for prirv32_mem_arbiter; inputs change 1ns after posedge,
// outputs are checked on the falling edge.
module tb_prirv32_mem_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_n;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic        if_gnt_o;
  logic        if_rvalid_o;
  logic [31:0] if_rdata_o;
  logic        ls_req_i;
  logic        ls_we_i;
  logic [3:0]  ls_be_i;
  logic [31:0] ls_addr_i;
  logic [31:0] ls_wdata_i;
  logic        ls_gnt_o;
  logic        ls_rvalid_o;
  logic [31:0] ls_rdata_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_ready_i;
  logic [31:0] mem_rdata_i;
  logic        if_err_o;
  logic        ls_err_o;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk_i = ~clk_i;

  prirv32_mem_arbiter #(
    .STARVE_LIMIT  (4),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk_i       (clk_i),
    .rst_n       (rst_n),
    .if_req_i    (if_req_i),
    .if_addr_i   (if_addr_i),
    .if_gnt_o    (if_gnt_o),
    .if_rvalid_o (if_rvalid_o),
    .if_rdata_o  (if_rdata_o),
    .ls_req_i    (ls_req_i),
    .ls_we_i     (ls_we_i),
    .ls_be_i     (ls_be_i),
    .ls_addr_i   (ls_addr_i),
    .ls_wdata_i  (ls_wdata_i),
    .ls_gnt_o    (ls_gnt_o),
    .ls_rvalid_o (ls_rvalid_o),
    .ls_rdata_o  (ls_rdata_o),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_be_o    (mem_be_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_ready_i (mem_ready_i),
    .mem_rdata_i (mem_rdata_i),
    .if_err_o    (if_err_o),
    .ls_err_o    (ls_err_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic mid();
    @(negedge clk_i);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [1:0]  exp_gnt;
    logic [31:0] exp_addr;
    int          busy_n;
    bit          seen;

    rst_n = 1'b0;   if_req_i = 1'b0; if_addr_i = '0;
    ls_req_i = 1'b0; ls_we_i = 1'b0; ls_be_i = '0; ls_addr_i = '0; ls_wdata_i = '0;
    mem_ready_i = 1'b0; mem_rdata_i = '0;

    // Reset state
    cyc(); cyc(); mid();
    chk("rst_mem_req", mem_req_o, 0);
    chk("rst_rvalid", {if_rvalid_o, ls_rvalid_o}, 0);
    chk("rst_mem_addr", mem_addr_o, 0);
    chk("rst_rdata", if_rdata_o | ls_rdata_o, 0);
    cyc(); rst_n = 1'b1;

    // IF only, minimum turnaround
    cyc(); if_req_i = 1'b1; if_addr_i = 32'h100; mid();
    chk("t1_if_gnt", if_gnt_o, 1);
    chk("t1_ls_gnt", ls_gnt_o, 0);
    chk("t1_req_c0", mem_req_o, 0);
    cyc(); if_req_i = 1'b0; if_addr_i = 32'hBAD; mem_ready_i = 1'b1; mem_rdata_i = 32'hDEADBEEF; mid();
    chk("t1_req_c1", mem_req_o, 1);
    chk("t1_addr", mem_addr_o, 32'h100);
    chk("t1_we", mem_we_o, 0);
    cyc(); mem_ready_i = 1'b0; mem_rdata_i = '0; mid();
    chk("t1_rvalid", if_rvalid_o, 1);
    chk("t1_rdata", if_rdata_o, 32'hDEADBEEF);
    chk("t1_err", {if_err_o, ls_err_o}, 0);
    cyc(); mid();
    chk("t1_rvalid_end", if_rvalid_o, 0);
    chk("t1_rdata_hold", if_rdata_o, 32'hDEADBEEF);
    chk("t1_req_end", mem_req_o, 0);

    // Simultaneous requests: store wins, IF follows
    cyc(); if_req_i = 1'b1; if_addr_i = 32'h10;
    ls_req_i = 1'b1; ls_we_i = 1'b1; ls_be_i = 4'b0011; ls_addr_i = 32'h200; ls_wdata_i = 32'h1234; mid();
    chk("t2_ls_gnt", ls_gnt_o, 1);
    chk("t2_if_gnt", if_gnt_o, 0);
    cyc(); ls_req_i = 1'b0; ls_addr_i = 32'hFFFFFFFC; ls_wdata_i = '0; ls_be_i = '0;
    mem_ready_i = 1'b1; mem_rdata_i = 32'hCAFEF00D; mid();
    chk("t2_req", mem_req_o, 1);
    chk("t2_we", mem_we_o, 1);
    chk("t2_be", mem_be_o, 4'b0011);
    chk("t2_addr", mem_addr_o, 32'h200);
    chk("t2_wdata", mem_wdata_o, 32'h1234);
    chk("t2_no_gnt_busy", if_gnt_o, 0);
    cyc(); mem_ready_i = 1'b0; mid();
    chk("t2_ls_rvalid", ls_rvalid_o, 1);
    chk("t2_st_rdata", ls_rdata_o, 0);
    chk("t2_no_gnt_resp", if_gnt_o, 0);
    chk("t2_if_rvalid", if_rvalid_o, 0);
    cyc(); mid();
    chk("t2_if_gnt_next", if_gnt_o, 1);
    chk("t2_ls_rvalid_end", ls_rvalid_o, 0);
    cyc(); if_req_i = 1'b0; mem_ready_i = 1'b1; mem_rdata_i = 32'h11111111; mid();
    chk("t2_if_addr", mem_addr_o, 32'h10);
    chk("t2_if_we", mem_we_o, 0);
    cyc(); mem_ready_i = 1'b0; mid();
    chk("t2_if_rvalid2", if_rvalid_o, 1);
    chk("t2_if_rdata", if_rdata_o, 32'h11111111);
    cyc(); mid();
    chk("t2_idle", if_rvalid_o, 0);

    // Starvation guard: both requesting continuously
    for (int t = 0; t < 6; t++) begin
      exp_gnt  = (t == 4) ? 2'b10 : 2'b01;
      exp_addr = (t == 4) ? 32'h2000 + 32'(t * 4) : 32'h1000 + 32'(t * 4);
      cyc(); if_req_i = 1'b1; ls_req_i = 1'b1; ls_we_i = 1'b0; ls_be_i = 4'hF;
      ls_addr_i = 32'h1000 + 32'(t * 4); if_addr_i = 32'h2000 + 32'(t * 4); mid();
      chk($sformatf("t3_gnt%0d", t), {if_gnt_o, ls_gnt_o}, exp_gnt);
      cyc(); mem_ready_i = 1'b1; mem_rdata_i = 32'hA0000000 + 32'(t); mid();
      chk($sformatf("t3_addr%0d", t), mem_addr_o, exp_addr);
      cyc(); mem_ready_i = 1'b0; mid();
      chk($sformatf("t3_rvalid%0d", t), {if_rvalid_o, ls_rvalid_o}, exp_gnt);
      chk($sformatf("t3_rdata%0d", t), (t == 4) ? if_rdata_o : ls_rdata_o, 32'hA0000000 + 32'(t));
    end
    cyc(); if_req_i = 1'b0; ls_req_i = 1'b0; mid();
    chk("t3_no_gnt", {if_gnt_o, ls_gnt_o}, 0);

    // Wait states: ready in the 6th BUSY cycle, IF request arrives during BUSY
    cyc(); ls_req_i = 1'b1; ls_we_i = 1'b0; ls_addr_i = 32'h300; mid();
    chk("t4_ls_gnt", ls_gnt_o, 1);
    for (int k = 1; k <= 6; k++) begin
      cyc(); ls_req_i = 1'b0; ls_addr_i = '0; if_req_i = 1'b1; if_addr_i = 32'h400;
      mem_ready_i = (k == 6); mem_rdata_i = 32'h55AA55AA; mid();
      chk($sformatf("t4_req%0d", k), mem_req_o, 1);
      chk($sformatf("t4_addr%0d", k), mem_addr_o, 32'h300);
      chk($sformatf("t4_gnt%0d", k), {if_gnt_o, ls_gnt_o}, 0);
      chk($sformatf("t4_rv%0d", k), ls_rvalid_o, 0);
    end
    cyc(); mem_ready_i = 1'b0; mid();
    chk("t4_rvalid", ls_rvalid_o, 1);
    chk("t4_rdata", ls_rdata_o, 32'h55AA55AA);
    chk("t4_no_gnt_resp", if_gnt_o, 0);
    cyc(); mid();
    chk("t4_if_gnt", if_gnt_o, 1);

    // Reset in the 2nd BUSY cycle of that fetch
    cyc(); if_req_i = 1'b0; mid();
    chk("t5_busy1", mem_req_o, 1);
    chk("t5_addr", mem_addr_o, 32'h400);
    cyc(); mid();
    chk("t5_busy2", mem_req_o, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("t5_async_req", mem_req_o, 0);
    chk("t5_async_rv", if_rvalid_o, 0);
    cyc(); mem_ready_i = 1'b1; mid();
    chk("t5_rst_rv", if_rvalid_o, 0);
    cyc(); rst_n = 1'b1; mid();
    chk("t5_rel_rv", if_rvalid_o, 0);
    chk("t5_rel_req", mem_req_o, 0);
    cyc(); mid();
    chk("t5_idle_ready_rv", {if_rvalid_o, ls_rvalid_o}, 0);
    chk("t5_idle_ready_req", mem_req_o, 0);
    cyc(); mem_ready_i = 1'b0; if_req_i = 1'b1; if_addr_i = 32'h404; mid();
    chk("t5_gnt", if_gnt_o, 1);
    cyc(); if_req_i = 1'b0; mem_ready_i = 1'b1; mem_rdata_i = 32'h600DF00D; mid();
    chk("t5_addr2", mem_addr_o, 32'h404);
    cyc(); mem_ready_i = 1'b0; mid();
    chk("t5_rvalid", if_rvalid_o, 1);
    chk("t5_rdata", if_rdata_o, 32'h600DF00D);
    cyc(); mid();
    chk("t5_rvalid_end", if_rvalid_o, 0);

`ifdef PRIRV32_MEM_TIMEOUT_EN
    // Timeout: memory never answers a load
    cyc(); ls_req_i = 1'b1; ls_we_i = 1'b0; ls_addr_i = 32'h500; mid();
    chk("t6_gnt", ls_gnt_o, 1);
    cyc(); ls_req_i = 1'b0;
    busy_n = 0;
    seen   = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      mid();
      if (ls_rvalid_o) seen = 1'b1;
      else begin
        busy_n++;
        cyc();
      end
    end
    chk("t6_seen", 32'(seen), 1);
    chk("t6_busy_cycles", busy_n, 8);
    chk("t6_ls_err", ls_err_o, 1);
    chk("t6_rdata", ls_rdata_o, 0);
    chk("t6_if_err", if_err_o, 0);
    cyc(); mid();
    chk("t6_err_end", ls_err_o, 0);
    chk("t6_req_end", mem_req_o, 0);
    chk("t6_rv_end", ls_rvalid_o, 0);
`else
    busy_n = 0;
    seen   = 1'b0;
    chk("t6_err_tied", {if_err_o, ls_err_o}, 2'(busy_n) | 2'(seen));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
